step_to_angle: RTL

- Receive end of the step/dir interface. Accepts asynchronous step and direction pulses from a driver output, an external controller or a loopback of the step generator.
- Filters and counts pulses into a signed microstep position.
- Measures the step period for velocity and motion detection.
- Converts position to output-shaft angle in signed Q16.16 degrees using a sequential multiplier. Used for closed-loop checking of the angle-to-step path.

---
 rtl/stepper_pkg.sv | 17 +
 rtl/step_input_sync.sv | 58 +++++
 rtl/step_to_angle.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the step/dir receive path.
// Angle format and conversion FSM state encoding.
package stepper_pkg;

   // Q16.16 output angle
   localparam int FRAC_BITS = 16;

   // 1.8 deg / (26.85 gear * 256 microsteps) in Q0.32
   localparam logic [31:0] DEG_PER_USTEP_DEF = 32'd1124730;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } conv_state_t;

endpackage

// File: rtl/step_input_sync.sv
// Synchronizes step/dir, filters short step pulses and
// emits a single-cycle event per accepted pulse.
module step_input_sync #(
   parameter int MIN_PULSE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic step,
   input  logic dir,
   output logic step_evt,
   output logic dir_s
);

   localparam int CW = $clog2(MIN_PULSE + 2);

   logic          step_q;
   logic          step_s;
   logic          dir_q;
   logic [CW-1:0] hcnt;
   logic          armed;

   // two-flop synchronizers on both asynchronous inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         step_q <= 1'b0;
         step_s <= 1'b0;
         dir_q  <= 1'b0;
         dir_s  <= 1'b0;
      end else begin
         step_q <= step;
         step_s <= step_q;
         dir_q  <= dir;
         dir_s  <= dir_q;
      end
   end

   // high-time counter, stops one past the threshold
   always_ff @(posedge clk) begin
      if (rst || !step_s)
         hcnt <= '0;
      else if (hcnt <= CW'(MIN_PULSE))
         hcnt <= hcnt + CW'(1);
   end

   assign step_evt = armed && enable && (hcnt == CW'(MIN_PULSE));

   // one count per pulse; re-armed once the line is low
   always_ff @(posedge clk) begin
      if (rst)
         armed <= 1'b0;
      else if (!step_s)
         armed <= 1'b1;
      else if (step_evt)
         armed <= 1'b0;
   end

endmodule

// File: rtl/step_to_angle.sv
// Counts filtered step/dir pulses into a position, measures
// step period and converts position to a Q16.16 angle.
module step_to_angle
   import stepper_pkg::*;
#(
   parameter int          SIZE          = 32,
   parameter int          SYSCLK        = 25000000,
   parameter int          MIN_PULSE     = 2,
   parameter int          TIMEOUT       = SYSCLK / 10,
   parameter logic [31:0] DEG_PER_USTEP = DEG_PER_USTEP_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            enable_i,
   input  logic            step_i,
   input  logic            dir_i,
   input  logic            zero_i,
   output logic [SIZE-1:0] position_o,
   output logic [SIZE-1:0] period_o,
   output logic            moving_o,
   output logic [SIZE-1:0] angle_o,
   output logic            angle_valid_o
);

   localparam int              PW  = 2 * SIZE;
   localparam int              BW  = $clog2(SIZE);
   localparam logic [SIZE-1:0] TMO = SIZE'(TIMEOUT);

   logic            evt;
   logic            dir_s;
   logic [SIZE-1:0] idle;
   logic [SIZE-1:0] idle_nxt;
   logic            dirty;
   logic            sign;
   logic [SIZE-1:0] mag;
   logic [PW-1:0]   mcand;
   logic [PW-1:0]   prod;
   logic [BW-1:0]   bitc;
   logic [SIZE-1:0] r;
   conv_state_t     state;
   conv_state_t     state_nxt;

   step_input_sync #(
      .MIN_PULSE(MIN_PULSE)
   ) u_sync (
      .clk     (clk_i),
      .rst     (rst_i),
      .enable  (enable_i),
      .step    (step_i),
      .dir     (dir_i),
      .step_evt(evt),
      .dir_s   (dir_s)
   );

   // idle counter: cleared by a step, saturates at the timeout
   always_comb begin
      idle_nxt = idle;
      if (evt)
         idle_nxt = '0;
      else if (idle < TMO)
         idle_nxt = idle + SIZE'(1);
   end

   // period capture and motion flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idle     <= TMO;
         period_o <= TMO;
         moving_o <= 1'b0;
      end else begin
         idle     <= idle_nxt;
         moving_o <= (idle_nxt < TMO);
         if (evt)
            period_o <= (idle < TMO) ? idle + SIZE'(1) : TMO;
      end
   end

   // position counter; zero wins over a coincident step
   always_ff @(posedge clk_i) begin
      if (rst_i)
         position_o <= '0;
      else if (zero_i)
         position_o <= '0;
      else if (evt)
         position_o <= dir_s ? position_o + SIZE'(1)
                             : position_o - SIZE'(1);
   end

   // conversion state register
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // conversion next-state
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (dirty) state_nxt = MUL;
         MUL:     if (bitc == BW'(SIZE - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign r = prod[SIZE+FRAC_BITS-1:FRAC_BITS];

   // latch, LSB-first shift-add multiply, signed result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dirty         <= 1'b0;
         sign          <= 1'b0;
         mag           <= '0;
         mcand         <= '0;
         prod          <= '0;
         bitc          <= '0;
         angle_o       <= '0;
         angle_valid_o <= 1'b0;
      end else begin
         angle_valid_o <= 1'b0;
         dirty <= zero_i || evt || (dirty && state != IDLE);
         unique case (state)
            IDLE: begin
               if (dirty) begin
                  sign  <= position_o[SIZE-1];
                  mag   <= position_o[SIZE-1] ? -position_o : position_o;
                  mcand <= PW'(DEG_PER_USTEP);
                  prod  <= '0;
                  bitc  <= '0;
               end
            end
            MUL: begin
               if (mag[0])
                  prod <= prod + mcand;
               mag   <= mag >> 1;
               mcand <= mcand << 1;
               bitc  <= bitc + BW'(1);
            end
            DONE: begin
               angle_o       <= sign ? -r : r;
               angle_valid_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
